xrv_div_iter: RTL and testbench

//  Parametrised iterative integer divider for the xriscv M-extension datapath (DIV/DIVU/REM/REMU).

---
 rtl/xrv_div_iter.sv | 162 ++++++++++++++++
 tb/tb_xrv_div_iter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xrv_div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, BPC quotient bits per cycle.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module xrv_div_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  dividend,
  input  logic [XLEN-1:0]  divisor,
  input  logic [1:0]       optype,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned N  = XLEN / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             sel_rem_q, sel_rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             a_sgn, b_sgn, div_zero, ovf;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic [XLEN:0]    rem_t;
  logic [XLEN-1:0]  quot_t, q_res, r_res;

  assign a_sgn    = ~optype[0] & dividend[XLEN-1];
  assign b_sgn    = ~optype[0] & divisor[XLEN-1];
  assign a_abs    = a_sgn ? (~dividend + 1'b1) : dividend;
  assign b_abs    = b_sgn ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = ~optype[0] & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);

  // Dividend bits are shifted out of the quotient register's top while
  // quotient bits enter at the bottom, so one register serves both.
  always_comb begin
    rem_t  = rem_q;
    quot_t = quot_q;
    for (int unsigned i = 0; i < BPC; i++) begin
      rem_t  = {rem_t[XLEN-1:0], quot_t[XLEN-1]};
      quot_t = {quot_t[XLEN-2:0], 1'b0};
      if (rem_t >= {1'b0, dvsr_q}) begin
        rem_t     = rem_t - {1'b0, dvsr_q};
        quot_t[0] = 1'b1;
      end
    end
    q_res = q_neg_q ? (~quot_t + 1'b1) : quot_t;
    r_res = r_neg_q ? (~rem_t[XLEN-1:0] + 1'b1) : rem_t[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          tag_d     = in_tag;
          sel_rem_d = optype[1];
          q_neg_d   = a_sgn ^ b_sgn;
          r_neg_d   = a_sgn;
          quot_d    = a_abs;
          dvsr_d    = b_abs;
          rem_d     = '0;
          cnt_d     = '0;
          if (div_zero) begin
            state_d   = DONE;
            result_d  = optype[1] ? dividend : '1;
            out_tag_d = in_tag;
          end else if (ovf) begin
            state_d   = DONE;
            result_d  = optype[1] ? '0 : dividend;
            out_tag_d = in_tag;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = rem_t;
        quot_d = quot_t;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d   = DONE;
          result_d  = sel_rem_q ? r_res : q_res;
          out_tag_d = tag_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      result_d  = result_q;
      out_tag_d = out_tag_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      tag_q     <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      sel_rem_q <= sel_rem_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_xrv_div_iter.sv
// Bench for xrv_div_iter: three instances (BPC 1, 2, 4) checked every cycle
// against an arithmetic reference model with single-op-in-flight tracking.
module tb_xrv_div_iter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned ND    = 3;
  localparam int unsigned NDIR  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid [ND];
  logic             in_ready [ND];
  logic [XLEN-1:0]  dividend [ND];
  logic [XLEN-1:0]  divisor  [ND];
  logic [1:0]       optype   [ND];
  logic [TAG_W-1:0] in_tag   [ND];
  logic             flush    [ND];
  logic             out_valid[ND];
  logic             out_ready[ND];
  logic [XLEN-1:0]  result   [ND];
  logic [TAG_W-1:0] out_tag  [ND];
  logic             busy     [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    xrv_div_iter #(.XLEN(XLEN), .BPC(1 << g), .TAG_W(TAG_W)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .dividend (dividend[g]),
      .divisor  (divisor[g]),
      .optype   (optype[g]),
      .in_tag   (in_tag[g]),
      .flush    (flush[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .result   (result[g]),
      .out_tag  (out_tag[g]),
      .busy     (busy[g])
    );
  end

  // Directed vectors: optype bit1 = remainder, bit0 = unsigned.
  logic [31:0] va [NDIR] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7, 32'hFFFFFFFF, 32'h80000000,
                             32'h80000000, 32'h5, 32'hFFFFFFFB, 32'h0, 32'h3, 32'h3,
                             32'h80000000, 32'h80000000, 32'd100, 32'd100};
  logic [31:0] vb [NDIR] = '{32'h2, 32'h2, 32'h2, 32'h1, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h0, 32'h0, 32'h5, 32'h7, 32'h7,
                             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9};
  logic [1:0]  vo [NDIR] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00,
                             2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11,
                             2'b01, 2'b11, 2'b00, 2'b10};
  logic [31:0] ve [NDIR] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                             32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h0, 32'h0, 32'h3,
                             32'h0, 32'h80000000, 32'hFFFFFFF2, 32'h2};

  int vectors     = 0;
  int miscompares = 0;
  bit tmo         = 1'b0;
  bit rnd_rdy     = 1'b0;

  bit          pend [ND];
  int          due  [ND];
  logic [31:0] eres [ND];
  logic [4:0]  etag [ND];

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    return (b == 32'h0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (b == 32'h0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  function automatic int lat(input int d, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    return is_special(a, b, op) ? 1 : (32 / (1 << d)) + 1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, d, $time, act, exp);
    end
  endtask

  // Compare process: model tracking and per-cycle output checks.
  initial begin
    int  cyc;
    bit  was_pend, exp_ov;
    cyc = 0;
    for (int d = 0; d < ND; d++) pend[d] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDIR; i++) chk("model_pin", i, model(va[i], vb[i], vo[i]), ve[i]);
    chk("lat_pin_bpc1", 0, 32'(lat(0, 32'd7, 32'd2, 2'b00)), 32'd33);
    chk("lat_pin_bpc2", 1, 32'(lat(1, 32'd7, 32'd2, 2'b00)), 32'd17);
    chk("lat_pin_bpc4", 2, 32'(lat(2, 32'd7, 32'd2, 2'b00)), 32'd9);
    chk("lat_pin_dz",   0, 32'(lat(0, 32'd5, 32'd0, 2'b00)), 32'd1);
    forever begin
      chk("watchdog", 0, 32'(tmo), 32'h0);
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          chk("rst_out_valid", d, 32'(out_valid[d]), 32'h0);
          chk("rst_result",    d, result[d], 32'h0);
          chk("rst_out_tag",   d, 32'(out_tag[d]), 32'h0);
          chk("rst_busy",      d, 32'(busy[d]), 32'h0);
          chk("rst_in_ready",  d, 32'(in_ready[d]), 32'h1);
          pend[d] = 1'b0;
        end else begin
          was_pend = pend[d];
          exp_ov   = pend[d] && (cyc >= due[d]);
          chk("out_valid", d, 32'(out_valid[d]), 32'(exp_ov));
          chk("busy",      d, 32'(busy[d]), 32'(pend[d]));
          chk("in_ready",  d, 32'(in_ready[d]), 32'(!pend[d] && !flush[d]));
          if (exp_ov && out_valid[d]) begin
            chk("result",  d, result[d], eres[d]);
            chk("out_tag", d, 32'(out_tag[d]), 32'(etag[d]));
          end
          if (flush[d] || (exp_ov && out_ready[d])) pend[d] = 1'b0;
          if (in_valid[d] && !was_pend && !flush[d]) begin
            pend[d] = 1'b1;
            due[d]  = cyc + lat(d, dividend[d], divisor[d], optype[d]);
            eres[d] = model(dividend[d], divisor[d], optype[d]);
            etag[d] = in_tag[d];
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      out_ready[1] = ($urandom_range(0, 3) != 0);
      out_ready[2] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic [4:0] tag);
    bit acc;
    dividend[d] = a;
    divisor[d]  = b;
    optype[d]   = op;
    in_tag[d]   = tag;
    in_valid[d] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = in_ready[d];
      tick();
      if (acc) break;
      if (k == 299) tmo = 1'b1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int k = 0; k < 300; k++) begin
      if (!pend[d]) return;
      tick();
    end
    tmo = 1'b1;
  endtask

  task automatic rand_ops(input int d, input int n);
    logic [31:0] a, b;
    int m;
    for (int i = 0; i < n; i++) begin
      m = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (m == 0) b = 32'h0;
      else if (m == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (m == 2) b = $urandom_range(0, 1) != 0 ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
      else if (m == 3) a = 32'($urandom_range(0, 20));
      issue(d, a, b, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
    end
    drain(d);
  endtask

  initial begin
    #4000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; dividend[d] = '0; divisor[d] = '0; optype[d] = '0;
      in_tag[d] = '0; flush[d] = 1'b0; out_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    for (int i = 0; i < NDIR; i++) begin
      issue(0, va[i], vb[i], vo[i], 5'(i + 1));
      drain(0);
    end

    // Consumer stall in DONE: result and tag must hold, no new accept.
    out_ready[0] = 1'b0;
    issue(0, 32'd1000, 32'd7, 2'b01, 5'd21);
    for (int k = 0; k < 60 && !out_valid[0]; k++) tick();
    repeat (10) tick();
    out_ready[0] = 1'b1;
    drain(0);

    // Flush in the 10th CALC cycle, then a fresh op.
    issue(0, 32'd12345, 32'd67, 2'b00, 5'd9);
    repeat (9) tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    tick();
    issue(0, 32'hFFFFFF00, 32'd16, 2'b00, 5'd10);
    drain(0);

    rnd_rdy = 1'b1;
    rand_ops(1, 1500);
    rand_ops(2, 1500);
    rnd_rdy = 1'b0;
    out_ready[1] = 1'b1;
    out_ready[2] = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
